req_collector: RTL and testbench

REQ_COLLECTOR -- requirements
Module: req_collector

---
 rtl/req_collector_pkg.sv | 21 ++
 rtl/req_slot.sv | 72 +++++++
 rtl/req_collector.sv | 61 ++++++
 tb/tb_req_collector.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/req_collector_pkg.sv
// Shared types and constants for the request collector.
// Slot state encoding and default pending depth.
package req_collector_pkg;

  localparam int CNT_W        = 2;
  localparam int MAX_PEND_DEF = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    GRANTED = 2'd2,
    GAP     = 2'd3
  } slot_state_t;

  typedef logic [CNT_W-1:0] cnt_t;

  function automatic cnt_t cnt_max(input int m);
    return cnt_t'(m);
  endfunction

endpackage

// File: rtl/req_slot.sv
// One client slot: pending counter, sticky overflow and
// the IDLE/PEND/GRANTED/GAP request handshake.
module req_slot
  import req_collector_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic       g,
  output logic       req,
  output cnt_t       count,
  output logic       ovf,
  output logic       active
);

  localparam cnt_t CMAX = cnt_max(MAX_PEND);

  slot_state_t state, state_nxt;
  cnt_t        count_nxt;
  logic        ovf_nxt;
  logic        dec;
  logic        full;
  logic        take;
  logic        drop;

  assign dec  = (state == PEND) && g;
  assign full = (count == CMAX);
  assign take = push && (!full || dec);
  assign drop = push && full && !dec;

  always_comb begin
    count_nxt = count;
    unique case ({take, dec})
      2'b10:   count_nxt = count + cnt_t'(1);
      2'b01:   count_nxt = count - cnt_t'(1);
      default: count_nxt = count;
    endcase
  end

  assign ovf_nxt = ovf | drop;

  // GAP looks at the post-update count so a push landing
  // in the gap cycle is not stranded in IDLE.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (take) state_nxt = PEND;
      PEND:    if (g) state_nxt = GRANTED;
      GRANTED: if (!g) state_nxt = GAP;
      GAP:     state_nxt = (count_nxt != '0) ? PEND : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      ovf   <= ovf_nxt;
    end
  end

  assign req    = (state == PEND);
  assign active = (state != IDLE) || (count != '0);

endmodule

// File: rtl/req_collector.sv
// Three independent request slots feeding a downstream arbiter.
// Client 1 maps to bit 2, client 3 to bit 0.
module req_collector
  import req_collector_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push1,
  input  logic       push2,
  input  logic       push3,
  input  logic       g1,
  input  logic       g2,
  input  logic       g3,
  output logic [2:0] req,
  output logic [1:0] pend1,
  output logic [1:0] pend2,
  output logic [1:0] pend3,
  output logic [2:0] ovf,
  output logic       busy
);

  logic [2:0] act;

  req_slot #(.MAX_PEND(MAX_PEND)) u_s1 (
    .clk    (clk),
    .reset  (reset),
    .push   (push1),
    .g      (g1),
    .req    (req[2]),
    .count  (pend1),
    .ovf    (ovf[2]),
    .active (act[2])
  );

  req_slot #(.MAX_PEND(MAX_PEND)) u_s2 (
    .clk    (clk),
    .reset  (reset),
    .push   (push2),
    .g      (g2),
    .req    (req[1]),
    .count  (pend2),
    .ovf    (ovf[1]),
    .active (act[1])
  );

  req_slot #(.MAX_PEND(MAX_PEND)) u_s3 (
    .clk    (clk),
    .reset  (reset),
    .push   (push3),
    .g      (g3),
    .req    (req[0]),
    .count  (pend3),
    .ovf    (ovf[0]),
    .active (act[0])
  );

  assign busy = |act;

endmodule

// File: tb/tb_req_collector.sv
// Scoreboard bench for req_collector: stimulus queues the
// expected post-edge outputs, a monitor pops and compares.
module tb_req_collector;

  logic       clk = 1'b0;
  logic       reset;
  logic       push1, push2, push3;
  logic       g1, g2, g3;
  logic [2:0] req;
  logic [1:0] pend1, pend2, pend3;
  logic [2:0] ovf;
  logic       busy;

  typedef struct {
    logic [2:0] req;
    logic [1:0] p1;
    logic [1:0] p2;
    logic [1:0] p3;
    logic [2:0] ovf;
    logic       busy;
    string      nm;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   fails  = 0;

  always #5 clk = ~clk;

  req_collector dut (
    .clk   (clk),
    .reset (reset),
    .push1 (push1),
    .push2 (push2),
    .push3 (push3),
    .g1    (g1),
    .g2    (g2),
    .g3    (g3),
    .req   (req),
    .pend1 (pend1),
    .pend2 (pend2),
    .pend3 (pend3),
    .ovf   (ovf),
    .busy  (busy)
  );

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      checks++;
      if (req !== e.req || pend1 !== e.p1 || pend2 !== e.p2 ||
          pend3 !== e.p3 || ovf !== e.ovf || busy !== e.busy) begin
        fails++;
        $display("FAIL %s: got req=%b p=%0d/%0d/%0d ovf=%b busy=%b, want req=%b p=%0d/%0d/%0d ovf=%b busy=%b",
                 e.nm, req, pend1, pend2, pend3, ovf, busy,
                 e.req, e.p1, e.p2, e.p3, e.ovf, e.busy);
      end
    end
  end

  // p/g bit 2 = client 1, bit 0 = client 3
  task automatic cyc(input logic [2:0] p, input logic [2:0] g,
                     input logic rst, input logic [2:0] er,
                     input logic [1:0] e1, input logic [1:0] e2,
                     input logic [1:0] e3, input logic [2:0] eo,
                     input logic eb, input string nm);
    exp_t e;
    @(negedge clk);
    reset = rst;
    {push1, push2, push3} = p;
    {g1, g2, g3} = g;
    @(posedge clk);
    #1;
    e.req = er; e.p1 = e1; e.p2 = e2; e.p3 = e3;
    e.ovf = eo; e.busy = eb; e.nm = nm;
    q.push_back(e);
  endtask

  initial begin
    reset = 1'b1;
    {push1, push2, push3} = 3'b000;
    {g1, g2, g3} = 3'b000;
    cyc(3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 3'b000, 0, "reset0");
    cyc(3'b111, 3'b111, 1, 3'b000, 0, 0, 0, 3'b000, 0, "reset_prio");

    // single push / grant / gap on client 3
    cyc(3'b001, 3'b000, 0, 3'b001, 0, 0, 1, 3'b000, 1, "c3_push");
    cyc(3'b000, 3'b000, 0, 3'b001, 0, 0, 1, 3'b000, 1, "c3_hold");
    cyc(3'b000, 3'b001, 0, 3'b000, 0, 0, 0, 3'b000, 1, "c3_grant");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 1, "c3_gap");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0, "c3_idle");

    // push landing in the GAP cycle
    cyc(3'b001, 3'b000, 0, 3'b001, 0, 0, 1, 3'b000, 1, "gp_push");
    cyc(3'b000, 3'b001, 0, 3'b000, 0, 0, 0, 3'b000, 1, "gp_grant");
    cyc(3'b001, 3'b000, 0, 3'b000, 0, 0, 1, 3'b000, 1, "gp_pushgap");
    cyc(3'b000, 3'b000, 0, 3'b001, 0, 0, 1, 3'b000, 1, "gp_repend");
    cyc(3'b000, 3'b001, 0, 3'b000, 0, 0, 0, 3'b000, 1, "gp_grant2");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 1, "gp_gap2");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0, "gp_idle");

    // client 1: three pushes, three grants
    cyc(3'b100, 3'b000, 0, 3'b100, 1, 0, 0, 3'b000, 1, "c1_p1");
    cyc(3'b100, 3'b000, 0, 3'b100, 2, 0, 0, 3'b000, 1, "c1_p2");
    cyc(3'b100, 3'b000, 0, 3'b100, 3, 0, 0, 3'b000, 1, "c1_p3");
    cyc(3'b000, 3'b100, 0, 3'b000, 2, 0, 0, 3'b000, 1, "c1_g1");
    cyc(3'b000, 3'b000, 0, 3'b000, 2, 0, 0, 3'b000, 1, "c1_gap1");
    cyc(3'b000, 3'b000, 0, 3'b100, 2, 0, 0, 3'b000, 1, "c1_pend2");
    cyc(3'b000, 3'b100, 0, 3'b000, 1, 0, 0, 3'b000, 1, "c1_g2");
    cyc(3'b000, 3'b000, 0, 3'b000, 1, 0, 0, 3'b000, 1, "c1_gap2");
    cyc(3'b000, 3'b000, 0, 3'b100, 1, 0, 0, 3'b000, 1, "c1_pend3");
    cyc(3'b000, 3'b100, 0, 3'b000, 0, 0, 0, 3'b000, 1, "c1_g3");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 1, "c1_gap3");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0, "c1_idle");

    // long grant: one decrement only; spurious g2
    cyc(3'b100, 3'b000, 0, 3'b100, 1, 0, 0, 3'b000, 1, "lg_push");
    cyc(3'b100, 3'b100, 0, 3'b000, 1, 0, 0, 3'b000, 1, "lg_g1");
    cyc(3'b000, 3'b110, 0, 3'b000, 1, 0, 0, 3'b000, 1, "lg_g2_spur");
    cyc(3'b000, 3'b100, 0, 3'b000, 1, 0, 0, 3'b000, 1, "lg_g3");
    cyc(3'b000, 3'b100, 0, 3'b000, 1, 0, 0, 3'b000, 1, "lg_g4");
    cyc(3'b000, 3'b100, 0, 3'b000, 1, 0, 0, 3'b000, 1, "lg_g5");
    cyc(3'b000, 3'b000, 0, 3'b000, 1, 0, 0, 3'b000, 1, "lg_gap");
    cyc(3'b000, 3'b000, 0, 3'b100, 1, 0, 0, 3'b000, 1, "lg_repend");
    cyc(3'b000, 3'b100, 0, 3'b000, 0, 0, 0, 3'b000, 1, "lg_grant");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 1, "lg_gap2");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0, "lg_idle");

    // client 2 overflow, sticky until reset
    cyc(3'b010, 3'b000, 0, 3'b010, 0, 1, 0, 3'b000, 1, "ov_p1");
    cyc(3'b010, 3'b000, 0, 3'b010, 0, 2, 0, 3'b000, 1, "ov_p2");
    cyc(3'b010, 3'b000, 0, 3'b010, 0, 3, 0, 3'b000, 1, "ov_p3");
    cyc(3'b010, 3'b000, 0, 3'b010, 0, 3, 0, 3'b010, 1, "ov_p4");
    cyc(3'b000, 3'b000, 0, 3'b010, 0, 3, 0, 3'b010, 1, "ov_hold");
    cyc(3'b000, 3'b000, 1, 3'b000, 0, 0, 0, 3'b000, 0, "ov_reset");

    // saturated push coinciding with a decrement
    cyc(3'b100, 3'b000, 0, 3'b100, 1, 0, 0, 3'b000, 1, "sd_p1");
    cyc(3'b100, 3'b000, 0, 3'b100, 2, 0, 0, 3'b000, 1, "sd_p2");
    cyc(3'b100, 3'b000, 0, 3'b100, 3, 0, 0, 3'b000, 1, "sd_p3");
    cyc(3'b100, 3'b100, 0, 3'b000, 3, 0, 0, 3'b000, 1, "sd_pushdec");
    cyc(3'b000, 3'b000, 0, 3'b000, 3, 0, 0, 3'b000, 1, "sd_gap");
    cyc(3'b000, 3'b000, 0, 3'b100, 3, 0, 0, 3'b000, 1, "sd_pend");
    cyc(3'b100, 3'b000, 0, 3'b100, 3, 0, 0, 3'b100, 1, "sd_drop");

    // everyone pending, then reset
    cyc(3'b011, 3'b000, 0, 3'b111, 3, 1, 1, 3'b100, 1, "all_pend");
    cyc(3'b100, 3'b010, 1, 3'b000, 0, 0, 0, 3'b000, 0, "all_reset");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0, "all_after");
    cyc(3'b000, 3'b000, 0, 3'b000, 0, 0, 0, 3'b000, 0, "all_quiet");

    begin
      int n;
      n = 0;
      while (q.size() > 0 && n < 10) begin
        @(posedge clk);
        n++;
      end
      if (q.size() > 0) begin
        fails++;
        $display("FAIL drain: got %0d unchecked entries, want 0",
                 q.size());
      end
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
